// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates, active-video and lock status
// from an 800x600 hsync/vsync pair and flags every timing violation.
// Optional build macro: VGA_RX_ERRCNT_EN adds the 8-bit saturating err_count;
// without it err_count is tied to zero.
module vga_timing_rx #(
  parameter int   H_ACTIVE    = 800,
  parameter int   H_TOTAL     = 1040,
  parameter int   H_SYNC      = 120,
  parameter int   H_BACK      = 64,
  parameter int   V_ACTIVE    = 600,
  parameter int   V_TOTAL     = 666,
  parameter int   V_BACK      = 23,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_LAST = 11'(H_SYNC - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_START     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] X_END       = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] Y_START     = 11'(V_BACK);
  localparam logic [10:0] Y_END       = 11'(V_BACK + V_ACTIVE);
  localparam logic [10:0] CNT_MAX     = 11'h7FF;
  localparam logic [7:0]  LOCK_CNT    = 8'(LOCK_FRAMES);

  logic        hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d, hs_prev_q, hs_prev_d;
  logic        vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_prev_q, vs_prev_d;
  logic        h_lead, h_trail, v_lead, v_line, viol;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        v_pend_q, v_pend_d;
  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        active_q, active_d, locked_q, locked_d;
  logic        frame_start_q, frame_start_d, err_q, err_d;
  logic        in_window;

  // Two-flop synchronizers plus one history flop; leading edge = move into SYNC_POL
  always_comb begin
    hs_meta_d = hsync;
    hs_sync_d = hs_meta_q;
    hs_prev_d = hs_sync_q;
    vs_meta_d = vsync;
    vs_sync_d = vs_meta_q;
    vs_prev_d = vs_sync_q;
    h_lead    = (hs_sync_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    h_trail   = (hs_sync_q != SYNC_POL) && (hs_prev_q == SYNC_POL);
    v_lead    = (vs_sync_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
  end

  // Pixel/line counters; a vsync edge (pending or same-cycle) makes the next line 0
  always_comb begin
    v_line   = h_lead && (v_pend_q || v_lead);
    h_cnt_d  = (h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 11'd1;
    v_cnt_d  = v_cnt_q;
    v_pend_d = v_pend_q;
    if (h_lead) begin
      h_cnt_d  = 11'd0;
      v_pend_d = 1'b0;
      if (v_line)
        v_cnt_d = 11'd0;
      else if (v_cnt_q != CNT_MAX)
        v_cnt_d = v_cnt_q + 11'd1;
    end else if (v_lead) begin
      v_pend_d = 1'b1;
    end
  end

  // Timing checks: line length, line timeout, hsync width, frame length, frame timeout
  always_comb begin
    viol = (h_lead  && (h_cnt_q != H_LAST))
        || (!h_lead && (h_cnt_q == H_LAST))
        || (h_trail && (h_cnt_q != H_SYNC_LAST))
        || (v_line  && (v_cnt_q != V_LAST))
        || (h_lead  && !v_line && (v_cnt_q == V_LAST));
  end

  // Lock FSM: search for a frame boundary, count clean frames, drop on any violation
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (v_line) begin
          state_d = ACQUIRE;
          good_d  = 8'd0;
        end
      end
      ACQUIRE: begin
        if (viol) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end else if (v_line) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 == LOCK_CNT)
            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Registered outputs: coordinates only inside the visible window while locked
  always_comb begin
    in_window     = (h_cnt_q >= X_START) && (h_cnt_q < X_END)
                 && (v_cnt_q >= Y_START) && (v_cnt_q < Y_END);
    locked_d      = (state_d == LOCKED);
    active_d      = in_window && locked_d;
    x_d           = active_d ? (h_cnt_q - X_START) : 11'd0;
    y_d           = active_d ? (v_cnt_q - Y_START) : 11'd0;
    frame_start_d = v_line && locked_d;
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_meta_q     <= ~SYNC_POL;
      hs_sync_q     <= ~SYNC_POL;
      hs_prev_q     <= ~SYNC_POL;
      vs_meta_q     <= ~SYNC_POL;
      vs_sync_q     <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 11'd0;
      v_pend_q      <= 1'b0;
      state_q       <= SEARCH;
      good_q        <= 8'd0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hs_meta_q     <= hs_meta_d;
      hs_sync_q     <= hs_sync_d;
      hs_prev_q     <= hs_prev_d;
      vs_meta_q     <= vs_meta_d;
      vs_sync_q     <= vs_sync_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      v_pend_q      <= v_pend_d;
      state_q       <= state_d;
      good_q        <= good_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;

`ifdef VGA_RX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating violation count, stepping in the same cycle err rises
  always_comb begin
    err_count_d = err_count_q;
    if (err_d && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  // Violation counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_count_q <= 8'd0;
    else
      err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed bench for vga_timing_rx. Horizontal timing is the
// nominal 1040-clock line; the frame is shortened to 4 lines (V_BACK=1,
// V_ACTIVE=2) so multi-frame lock sequences stay short.
module tb_vga_timing_rx;

  localparam int HT = 1040;
  localparam int HS = 120;
  localparam int VA = 2;
  localparam int VT = 4;
  localparam int VB = 1;

`ifdef VGA_RX_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [10:0] x, y;
  logic        active, locked, frame_start, err;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int line_idx = 0;

  logic [10:0] cap_x, cap_y;
  logic        cap_act, cap_lock, cap_fs, cap_err;

  vga_timing_rx #(
    .V_ACTIVE (VA),
    .V_TOTAL  (VT),
    .V_BACK   (VB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .y           (y),
    .active      (active),
    .locked      (locked),
    .frame_start (frame_start),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Tally of err pulses seen on the output
  always @(negedge clk) begin
    if (err === 1'b1) err_pulses <= err_pulses + 1;
  end

  function automatic logic [7:0] exp_ec(input int n);
    if (!ERRCNT_EN) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  // One line of len clocks, hsync high for sw clocks, vsync high on line 0;
  // outputs are captured #1 after the posedge of clock index cap_c.
  task automatic drive_line(input int len, input int sw, input int cap_c);
    logic vs_lvl;
    vs_lvl = (line_idx == 0);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      hsync = (c < sw);
      vsync = vs_lvl;
      if (c == cap_c) begin
        cap_x = x; cap_y = y; cap_act = active;
        cap_lock = locked; cap_fs = frame_start; cap_err = err;
      end
    end
    line_idx = (line_idx + 1) % VT;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (x !== 11'd0) begin failures++; $display("FAIL rst_x got=%0d exp=0", x); end
    checks++; if (y !== 11'd0) begin failures++; $display("FAIL rst_y got=%0d exp=0", y); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", active); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_errcnt got=%0d exp=0", err_count); end
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL idle_locked got=%b exp=0", locked); end
    checks++; if (err_pulses !== 0) begin failures++; $display("FAIL idle_err got=%0d exp=0", err_pulses); end
  endtask

  task automatic test_lock();
    int base;
    base = err_pulses;
    line_idx = 3;
    drive_line(HT, HS, -1);
    repeat (7) drive_line(HT, HS, -1);
    drive_line(HT, HS, 1000);
    checks++; if (cap_lock !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", cap_lock); end
    drive_line(HT, HS, 3);
    checks++; if (cap_lock !== 1'b1) begin failures++; $display("FAIL lock_rise got=%b exp=1", cap_lock); end
    drive_line(HT, HS, 188);
    checks++; if (cap_x !== 11'd0 || cap_y !== 11'd0 || cap_act !== 1'b1) begin
      failures++; $display("FAIL probe_first x=%0d y=%0d act=%b exp 0 0 1", cap_x, cap_y, cap_act); end
    drive_line(HT, HS, 987);
    checks++; if (cap_x !== 11'd799 || cap_y !== 11'd1 || cap_act !== 1'b1) begin
      failures++; $display("FAIL probe_last x=%0d y=%0d act=%b exp 799 1 1", cap_x, cap_y, cap_act); end
    drive_line(HT, HS, 188);
    checks++; if (cap_x !== 11'd0 || cap_y !== 11'd0 || cap_act !== 1'b0) begin
      failures++; $display("FAIL probe_vblank x=%0d y=%0d act=%b exp 0 0 0", cap_x, cap_y, cap_act); end
    drive_line(HT, HS, 3);
    checks++; if (cap_fs !== 1'b1) begin failures++; $display("FAIL frame_start got=%b exp=1", cap_fs); end
    checks++; if (err_pulses - base !== 0) begin failures++; $display("FAIL lock_err got=%0d exp=0", err_pulses - base); end
    checks++; if (err_count !== exp_ec(0)) begin failures++; $display("FAIL lock_errcnt got=%0d exp=%0d", err_count, exp_ec(0)); end
  endtask

  task automatic test_short_line();
    int base;
    base = err_pulses;
    drive_line(HT, HS, 187);
    checks++; if (cap_act !== 1'b0 || cap_x !== 11'd0 || cap_lock !== 1'b1) begin
      failures++; $display("FAIL probe_hfront act=%b x=%0d lock=%b exp 0 0 1", cap_act, cap_x, cap_lock); end
    drive_line(HT - 1, HS, 988);
    checks++; if (cap_act !== 1'b0 || cap_lock !== 1'b1) begin
      failures++; $display("FAIL probe_hback act=%b lock=%b exp 0 1", cap_act, cap_lock); end
    drive_line(HT, HS, 3);
    checks++; if (cap_err !== 1'b1 || cap_lock !== 1'b0) begin
      failures++; $display("FAIL short_line err=%b lock=%b exp 1 0", cap_err, cap_lock); end
    repeat (8) drive_line(HT, HS, -1);
    drive_line(HT, HS, 3);
    checks++; if (cap_lock !== 1'b1) begin failures++; $display("FAIL relock got=%b exp=1", cap_lock); end
    checks++; if (err_pulses - base !== 1) begin failures++; $display("FAIL short_pulses got=%0d exp=1", err_pulses - base); end
    checks++; if (err_count !== exp_ec(1)) begin failures++; $display("FAIL short_errcnt got=%0d exp=%0d", err_count, exp_ec(1)); end
  endtask

  task automatic test_hsync_stop();
    int base;
    base = err_pulses;
    drive_line(1100, 0, 3);
    checks++; if (cap_err !== 1'b1 || cap_lock !== 1'b0) begin
      failures++; $display("FAIL timeout err=%b lock=%b exp 1 0", cap_err, cap_lock); end
    checks++; if (cap_x !== 11'd0 || cap_y !== 11'd0 || cap_act !== 1'b0) begin
      failures++; $display("FAIL timeout_xy x=%0d y=%0d act=%b exp 0 0 0", cap_x, cap_y, cap_act); end
    checks++; if (err_pulses - base !== 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", err_pulses - base); end
    checks++; if (err_count !== exp_ec(2)) begin failures++; $display("FAIL timeout_errcnt got=%0d exp=%0d", err_count, exp_ec(2)); end
  endtask

  task automatic test_pulse_width();
    int base;
    base = err_pulses;
    repeat (10) drive_line(HT, HS, -1);
    drive_line(HT, HS, 3);
    checks++; if (cap_lock !== 1'b1 || err_pulses - base !== 0) begin
      failures++; $display("FAIL pw_relock lock=%b pulses=%0d exp 1 0", cap_lock, err_pulses - base); end
    drive_line(HT, HS - 1, 122);
    checks++; if (cap_err !== 1'b1 || cap_lock !== 1'b0) begin
      failures++; $display("FAIL pw_narrow err=%b lock=%b exp 1 0", cap_err, cap_lock); end
    checks++; if (err_pulses - base !== 1) begin failures++; $display("FAIL pw_pulses got=%0d exp=1", err_pulses - base); end
    checks++; if (err_count !== exp_ec(3)) begin failures++; $display("FAIL pw_errcnt got=%0d exp=%0d", err_count, exp_ec(3)); end
  endtask

  // Each burst: aligned vsync+hsync enters ACQUIRE, the 4-clock hsync pulse then fails
  task automatic test_err_saturate();
    int base;
    base = err_pulses;
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        hsync = (c < 4);
        vsync = (c < 4);
      end
      if (i == 99) begin
        checks++; if (err_count !== exp_ec(103)) begin failures++; $display("FAIL sat_mid got=%0d exp=%0d", err_count, exp_ec(103)); end
      end
      if (i == 251) begin
        checks++; if (err_count !== exp_ec(255)) begin failures++; $display("FAIL sat_reach got=%0d exp=%0d", err_count, exp_ec(255)); end
      end
    end
    checks++; if (err_count !== exp_ec(303)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", err_count, exp_ec(303)); end
    checks++; if (err_pulses - base !== 300) begin failures++; $display("FAIL sat_pulses got=%0d exp=300", err_pulses - base); end
  endtask

  task automatic test_reset_midline();
    int base;
    base = err_pulses;
    line_idx = 0;
    repeat (8) drive_line(HT, HS, -1);
    drive_line(HT, HS, 3);
    checks++; if (cap_lock !== 1'b1 || err_pulses - base !== 0) begin
      failures++; $display("FAIL mr_lock lock=%b pulses=%0d exp 1 0", cap_lock, err_pulses - base); end
    for (int c = 0; c < HT; c++) begin
      @(posedge clk); #1;
      hsync = (c < HS);
      vsync = 1'b0;
      if (c == 499) begin
        checks++; if (x !== 11'd311 || y !== 11'd0 || active !== 1'b1) begin
          failures++; $display("FAIL mr_pre x=%0d y=%0d act=%b exp 311 0 1", x, y, active); end
      end
      if (c == 500) begin
        reset_n = 1'b0;
        #1;
        checks++; if (x !== 11'd0 || y !== 11'd0 || active !== 1'b0 || locked !== 1'b0
                      || frame_start !== 1'b0 || err !== 1'b0 || err_count !== 8'd0) begin
          failures++; $display("FAIL mr_async x=%0d y=%0d act=%b lock=%b fs=%b err=%b cnt=%0d exp all 0",
                               x, y, active, locked, frame_start, err, err_count); end
      end
      if (c == 503) reset_n = 1'b1;
    end
    base = err_pulses;
    line_idx = 2;
    drive_line(HT, HS, -1);
    drive_line(HT, HS, 1000);
    checks++; if (cap_lock !== 1'b0) begin failures++; $display("FAIL mr_search got=%b exp=0", cap_lock); end
    drive_line(HT, HS, -1);
    checks++; if (err_pulses - base !== 0) begin failures++; $display("FAIL mr_noerr got=%0d exp=0", err_pulses - base); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_hsync_stop();
    test_pulse_width();
    test_err_saturate();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
